alu_exec_sequencer: RTL

//  Issue/writeback stage wrapped around the 8-bit combinational ALU. Accepts one

---
 rtl/alu_exec_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_sequencer.sv
// Issue/writeback sequencer around the 8-bit combinational ALU: regfile, operand latches, flags.
// Optional macro ALU_EXEC_DIVZERO_TRAP_EN suppresses divide-by-zero writeback and pulses div_trap.
module alu_exec_sequencer #(
  parameter int unsigned NREGS  = 4,
  parameter int unsigned RA_W   = $clog2(NREGS),
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opcode,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              div_trap,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OpCmp = 4'hF;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [3:0]        op_q;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        cap_flags_q;

  logic              accept;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flags_we;
  logic              trap_hit;

`ifdef ALU_EXEC_DIVZERO_TRAP_EN
  // DIV/MOD by zero: keep rd intact, flags still reflect the ALU's overflow marker
  assign trap_hit = ((op_q == 4'h4) || (op_q == 4'h5)) && (b_q == '0);
`else
  assign trap_hit = 1'b0;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign dbg_data   = rf_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    div_trap    = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;
    flags_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A direct load owns the cycle; the instruction waits
        instr_ready = !ld_valid && !rst;
        accept      = instr_ready && instr_valid;
        rf_we       = ld_valid;
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        done     = 1'b1;
        div_trap = trap_hit;
        flags_we = 1'b1;
        rf_we    = (op_q != OpCmp) && !trap_hit;
        rf_waddr = rd_q;
        rf_wdata = res_q;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cap_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      if (rf_we) begin
        rf_q[rf_waddr] <= rf_wdata;
      end
      // Operands are sampled at accept, so rd aliasing a source sees the old value
      if (accept) begin
        op_q <= instr_opcode;
        rd_q <= instr_rd;
        a_q  <= rf_q[instr_rs1];
        b_q  <= rf_q[instr_rs2];
      end
      if (state_q == StExec) begin
        res_q       <= alu_result;
        cap_flags_q <= {alu_c, alu_z, alu_v, alu_n};
      end
      if (flags_we) begin
        flags_q <= cap_flags_q;
      end
    end
  end

endmodule
